// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the 9-bit processor fetch stage.
//   fetch_state_t : fetch sequencer states (IDLE, PRIME, RUN, FLUSH, DONE)
//   HALT_INSTR    : machine word that stops the program
//   FETCH_*       : default widths for PC, instruction word and branch-target LUT index
package fetch_pkg;

  localparam int unsigned FETCH_PC_W   = 10;
  localparam int unsigned FETCH_IW     = 9;
  localparam int unsigned FETCH_LUT_AW = 4;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// branch_lut: 2^AW x DW register file holding absolute branch targets.
//   clk, rst_n : clock and synchronous active-low reset (clears every entry)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port; a same-cycle write to the
//                      same entry is not visible until the next cycle
module branch_lut #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];

  // Entry storage: cleared on reset, written on any cycle with we set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, ROM addressing and in-order word delivery.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, done         : start pulse / halted flag (held until next start)
//   instr_addr          : ROM address (the pc register)
//   instr_rdata         : ROM data, one cycle behind instr_addr
//   instr, instr_valid  : word to the decoder and its live/in-order flag
//   branch_taken/idx    : same-cycle taken-branch report from execute
//   lut_we/waddr/wdata  : branch-target LUT write port
// Optional build macro FETCH_PERF_EN adds cycle_cnt and retired_cnt outputs.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W   = FETCH_PC_W,
  parameter int unsigned IW     = FETCH_IW,
  parameter int unsigned LUT_AW = FETCH_LUT_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [IW-1:0]     instr_rdata,
  output logic [IW-1:0]     instr,
  output logic              instr_valid,
  input  logic              branch_taken,
  input  logic [LUT_AW-1:0] branch_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);

  fetch_state_t    state_r;
  logic [PC_W-1:0] pc_r;
  logic            instr_valid_r;
  logic            done_r;
  logic [PC_W-1:0] lut_target_s;
  logic            halt_s;

  branch_lut #(
    .AW (LUT_AW),
    .DW (PC_W)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (branch_idx),
    .rdata (lut_target_s)
  );

  // Halt detection on the word currently presented to the decoder.
  always_comb begin
    halt_s = 1'b0;
    if (instr_rdata == IW'(HALT_INSTR)) begin
      halt_s = 1'b1;
    end else begin
      halt_s = 1'b0;
    end
  end

  // Fetch sequencer: state, pc and the registered valid/done flags.
  // instr_valid_r is set exactly for the cycles spent in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= '0;
      instr_valid_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          instr_valid_r <= 1'b0;
          done_r        <= 1'b0;
          pc_r          <= '0;
          if (start) begin
            state_r <= PRIME;
          end else begin
            state_r <= IDLE;
          end
        end
        PRIME: begin
          // Address 0 is on the bus this cycle; its word arrives in RUN.
          pc_r          <= PC_W'(1);
          state_r       <= RUN;
          instr_valid_r <= 1'b1;
        end
        RUN: begin
          if (halt_s) begin
            // Halt wins over a same-cycle branch; pc is left untouched.
            state_r       <= DONE;
            done_r        <= 1'b1;
            instr_valid_r <= 1'b0;
          end else if (branch_taken) begin
            // Word already fetched from pc is wrong-path: squash it in FLUSH.
            pc_r          <= lut_target_s;
            state_r       <= FLUSH;
            instr_valid_r <= 1'b0;
          end else begin
            pc_r          <= pc_r + PC_W'(1);
            state_r       <= RUN;
            instr_valid_r <= 1'b1;
          end
        end
        FLUSH: begin
          pc_r          <= pc_r + PC_W'(1);
          state_r       <= RUN;
          instr_valid_r <= 1'b1;
        end
        DONE: begin
          instr_valid_r <= 1'b0;
          if (start) begin
            pc_r    <= '0;
            done_r  <= 1'b0;
            state_r <= PRIME;
          end else begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        default: begin
          state_r       <= IDLE;
          pc_r          <= '0;
          instr_valid_r <= 1'b0;
          done_r        <= 1'b0;
        end
      endcase
    end
  end

  assign instr_addr  = pc_r;
  assign instr       = instr_rdata;
  assign instr_valid = instr_valid_r;
  assign done        = done_r;

`ifdef FETCH_PERF_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] retired_cnt_r;
  logic        perf_clr_s;
  logic        active_s;

  // Counter control: clear on an accepted start, count while fetching.
  always_comb begin
    perf_clr_s = 1'b0;
    active_s   = 1'b0;
    if ((state_r == IDLE || state_r == DONE) && start) begin
      perf_clr_s = 1'b1;
    end else begin
      perf_clr_s = 1'b0;
    end
    if (state_r == PRIME || state_r == RUN || state_r == FLUSH) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
  end

  // Performance counters; they hold their value once DONE is reached.
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr_s) begin
      cycle_cnt_r   <= 32'd0;
      retired_cnt_r <= 32'd0;
    end else begin
      if (active_s) begin
        cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (instr_valid_r) begin
        retired_cnt_r <= retired_cnt_r + 32'd1;
      end else begin
        retired_cnt_r <= retired_cnt_r;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_r;
  assign retired_cnt = retired_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch. A behavioural ROM and
// a program-level reference (next-instruction address plus branch targets
// from a LUT copy) predict every cycle's valid flag and word.
// Branch words in this bench: instr[8:7] == 2'b10, target index = instr[3:0].
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       done;
  logic [9:0] instr_addr;
  logic [8:0] instr_rdata;
  logic [8:0] instr;
  logic       instr_valid;
  logic       branch_taken;
  logic [3:0] branch_idx;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [9:0] lut_wdata;
`ifdef FETCH_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;
`endif

  logic [8:0] rom [1024];
  logic [9:0] lut_m [16];
  logic       halt_br;
  int         n_pass;
  int         n_total;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .done         (done),
    .instr_addr   (instr_addr),
    .instr_rdata  (instr_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata)
`ifdef FETCH_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .retired_cnt  (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) instr_rdata <= rom[instr_addr];

  // Execute-stage stand-in: flags branch-coded words regardless of validity.
  always_comb begin
    branch_taken = (instr[8:7] == 2'b10) || (halt_br && instr == 9'h1FF);
    branch_idx   = instr[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [8:0] plain_word();
    logic [8:0] w;
    do w = 9'($urandom); while (w[8:7] == 2'b10 || w == 9'h1FF);
    return w;
  endfunction

  task automatic fill_plain();
    for (int i = 0; i < 1024; i++) rom[i] = plain_word();
  endtask

  task automatic write_lut(input logic [3:0] idx, input logic [9:0] val);
    @(negedge clk);
    lut_we = 1'b1; lut_waddr = idx; lut_wdata = val;
    @(negedge clk);
    lut_we = 1'b0;
    lut_m[idx] = val;
  endtask

  // Start a program at 0 and follow it to its halt. Optional hooks at model
  // cycle wr_cyc (LUT write) and pt_cyc (ROM patch); cycle 0 is PRIME.
  task automatic run_prog(input int wr_cyc, input logic [3:0] wr_idx, input logic [9:0] wr_dat,
                          input int pt_cyc, input logic [9:0] pt_addr, input logic [8:0] pt_word);
    int         c;
    int         phase;   // 0 priming, 1 expect a word, 2 expect a bubble
    int         nret;
    bit         halted;
    logic [9:0] a;
    logic [9:0] hpc;
    logic [8:0] w;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0; phase = 0; nret = 0; halted = 1'b0; a = 10'd0; hpc = 10'd0;
    while (!halted && c < 3000) begin
      chk("done_low", done, 0);
      if (phase == 0) begin
        chk("prime_valid", instr_valid, 0);
        chk("prime_addr", instr_addr, 0);
        phase = 1;
      end else if (phase == 2) begin
        chk("bubble_valid", instr_valid, 0);
        phase = 1;
      end else begin
        w = rom[a];
        chk("run_valid", instr_valid, 1);
        chk("instr_word", instr, w);
        nret++;
        if (w == 9'h1FF) begin
          halted = 1'b1;
          hpc = a + 10'd1;
        end else if (w[8:7] == 2'b10) begin
          a = lut_m[w[3:0]];
          phase = 2;
        end else begin
          a = a + 10'd1;
        end
      end
      if (c == wr_cyc) begin
        lut_we = 1'b1; lut_waddr = wr_idx; lut_wdata = wr_dat;
        lut_m[wr_idx] = wr_dat;
      end
      if (c == pt_cyc) rom[pt_addr] = pt_word;
      @(negedge clk);
      lut_we = 1'b0;
      c++;
    end
    if (!halted) begin
      chk("halt_timeout", 0, 1);
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk("done_high", done, 1);
        chk("done_valid", instr_valid, 0);
        chk("done_pc_hold", instr_addr, hpc);
`ifdef FETCH_PERF_EN
        chk("cycle_cnt", cycle_cnt, c);
        chk("retired_cnt", retired_cnt, nret);
`endif
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int k;
    int t;
    int len;
    logic [3:0] idx;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; halt_br = 1'b0;
    lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 10'd0;
    for (int i = 0; i < 16; i++) lut_m[i] = 10'd0;
    fill_plain();
    repeat (3) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", instr_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_addr", instr_addr, 0);

    // Halt priority over a same-cycle taken branch (target 0x200 must not load).
    write_lut(4'd15, 10'h200);
    rom[1] = 9'h1FF;
    halt_br = 1'b1;
    run_prog(-1, 4'd0, 10'd0, -1, 10'd0, 9'd0);
    halt_br = 1'b0;

    // Linear run, restarted from DONE.
    for (int i = 0; i < 5; i++) rom[i] = 9'(i + 1);
    rom[5] = 9'h1FF;
    run_prog(-1, 4'd0, 10'd0, -1, 10'd0, 9'd0);

    // Branch via lut[3] = 0x040 from address 2.
    fill_plain();
    write_lut(4'd3, 10'h040);
    rom[2] = 9'h103;
    rom[10'h042] = 9'h1FF;
    run_prog(-1, 4'd0, 10'd0, -1, 10'd0, 9'd0);

    // PC wrap 0x3FF -> 0x000 with no bubble; branch word at 1 later becomes halt.
    fill_plain();
    write_lut(4'd1, 10'h3FE);
    rom[1] = 9'h101;
    run_prog(-1, 4'd0, 10'd0, 3, 10'd1, 9'h1FF);

    // LUT read-old hazard: write lut[5]=0x100 in the branch cycle (old 0x020).
    fill_plain();
    write_lut(4'd5, 10'h020);
    rom[2] = 9'h105;
    rom[10'h021] = 9'h105;
    rom[10'h101] = 9'h1FF;
    run_prog(3, 4'd5, 10'h100, -1, 10'd0, 9'd0);

    // Randomised programs: straight line, one branch, halt in target region.
    for (int it = 0; it < 6; it++) begin
      fill_plain();
      k = int'($urandom_range(1, 30));
      t = int'($urandom_range(64, 900));
      len = int'($urandom_range(0, 15));
      idx = 4'($urandom);
      write_lut(idx, 10'(t));
      rom[k] = {2'b10, 3'($urandom), idx};
      if ($urandom_range(0, 1) == 1) rom[k + 1] = 9'h1FF;
      rom[t + len] = 9'h1FF;
      run_prog(-1, 4'd0, 10'd0, -1, 10'd0, 9'd0);
    end

    // Reset mid-run: everything back to idle, LUT cleared.
    fill_plain();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", instr_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", instr_addr, 0);
    for (int i = 0; i < 16; i++) lut_m[i] = 10'd0;
    @(negedge clk);
    chk("post_rst_idle_addr", instr_addr, 0);
    chk("post_rst_idle_valid", instr_valid, 0);
    rom[1] = 9'h105;
    run_prog(-1, 4'd0, 10'd0, 3, 10'd1, 9'h1FF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
